aurora_tx_arbiter: RTL and testbench

- Shares the single Aurora LocalLink TX port of `main` (3-lane GTX channel, 48-bit user data) between NREQ frame sources.
- Arbitrates round-robin, one whole frame per grant.
- Passes beats through with zero added latency.
- Gates all traffic on channel_up; a frame cut by a link drop is drained and flagged.

---
 rtl/aurora_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_aurora_tx_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_tx_arbiter.sv
// Round-robin, frame-atomic arbiter sharing one Aurora LocalLink TX port between NREQ sources.
// Define AURORA_TX_ARB_STATS_EN to add per-requester completed-frame counters (frame_cnt).
module aurora_tx_arbiter #(
    parameter int NREQ   = 3,
    parameter int DWIDTH = 48,
    parameter int REM_W  = 3
) (
    input  logic                    user_clk,
    input  logic                    sys_rst_n,
    input  logic                    channel_up,
    input  logic [NREQ*DWIDTH-1:0]  req_d,
    input  logic [NREQ*REM_W-1:0]   req_rem,
    input  logic [NREQ-1:0]         req_sof_n,
    input  logic [NREQ-1:0]         req_eof_n,
    input  logic [NREQ-1:0]         req_src_rdy_n,
    output logic [NREQ-1:0]         req_dst_rdy_n,
    output logic [DWIDTH-1:0]       tx_d,
    output logic [REM_W-1:0]        tx_rem,
    output logic                    tx_sof_n,
    output logic                    tx_eof_n,
    output logic                    tx_src_rdy_n,
    input  logic                    tx_dst_rdy_n,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic                    frame_dropped
`ifdef AURORA_TX_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]      frame_cnt
`endif
);
    localparam int IDXW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]   gidx_q, gidx_d;
    logic [IDXW-1:0]   rr_q, rr_d;
    logic              dropped_q, dropped_d;
    logic [NREQ-1:0]   req_vec;
    logic              found;
    logic [IDXW-1:0]   pick;
    logic [IDXW-1:0]   gidx_inc;
    logic [DWIDTH-1:0] sel_d;
    logic [REM_W-1:0]  sel_rem;
    logic              sel_sof_n;
    logic              sel_eof_n;
    logic              sel_src_rdy_n;
`ifdef AURORA_TX_ARB_STATS_EN
    logic [NREQ*16-1:0] frame_cnt_q, frame_cnt_d;
`endif

    assign req_vec       = ~req_src_rdy_n & ~req_sof_n;
    assign sel_d         = req_d[gidx_q*DWIDTH +: DWIDTH];
    assign sel_rem       = req_rem[gidx_q*REM_W +: REM_W];
    assign sel_sof_n     = req_sof_n[gidx_q];
    assign sel_eof_n     = req_eof_n[gidx_q];
    assign sel_src_rdy_n = req_src_rdy_n[gidx_q];
    assign gidx_inc      = (gidx_q == IDXW'(NREQ - 1)) ? '0 : gidx_q + IDXW'(1);

    // rr_q holds the first index to consider, so a finished owner g leaves g+1 as top priority.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_vec[(int'(rr_q) + k) % NREQ]) begin
                found = 1'b1;
                pick  = IDXW'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        rr_d          = rr_q;
        dropped_d     = 1'b0;
        tx_d          = '0;
        tx_rem        = '0;
        tx_sof_n      = 1'b1;
        tx_eof_n      = 1'b1;
        tx_src_rdy_n  = 1'b1;
        req_dst_rdy_n = '1;
`ifdef AURORA_TX_ARB_STATS_EN
        frame_cnt_d   = frame_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (channel_up && found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    gidx_d        = pick;
                    state_d       = XFER;
                end
            end
            XFER: begin
                tx_d                  = sel_d;
                tx_rem                = sel_rem;
                tx_sof_n              = sel_sof_n;
                tx_eof_n              = sel_eof_n;
                tx_src_rdy_n          = sel_src_rdy_n;
                req_dst_rdy_n[gidx_q] = tx_dst_rdy_n;
                // A final beat wins over a simultaneous link drop: the frame did reach Aurora.
                if (!sel_src_rdy_n && !tx_dst_rdy_n && !sel_eof_n) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = gidx_inc;
`ifdef AURORA_TX_ARB_STATS_EN
                    frame_cnt_d[gidx_q*16 +: 16] = frame_cnt_q[gidx_q*16 +: 16] + 16'd1;
`endif
                end else if (!channel_up) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                req_dst_rdy_n[gidx_q] = 1'b0;
                if (!sel_src_rdy_n && !sel_eof_n) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    rr_d      = gidx_inc;
                    dropped_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_q        <= '0;
            dropped_q   <= 1'b0;
`ifdef AURORA_TX_ARB_STATS_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_q        <= rr_d;
            dropped_q   <= dropped_d;
`ifdef AURORA_TX_ARB_STATS_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign grant         = grant_q;
    assign busy          = (state_q != IDLE);
    assign frame_dropped = dropped_q;
`ifdef AURORA_TX_ARB_STATS_EN
    assign frame_cnt     = frame_cnt_q;
`endif

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Bench for aurora_tx_arbiter: directed scenarios plus randomized traffic against a frame-level model.
// Build with AURORA_TX_ARB_STATS_EN defined to also cover frame_cnt.
module tb_aurora_tx_arbiter;
    localparam int NREQ   = 3;
    localparam int DWIDTH = 48;
    localparam int REM_W  = 3;

    logic                   user_clk = 1'b0;
    logic                   sys_rst_n;
    logic                   channel_up;
    logic [NREQ*DWIDTH-1:0] req_d;
    logic [NREQ*REM_W-1:0]  req_rem;
    logic [NREQ-1:0]        req_sof_n;
    logic [NREQ-1:0]        req_eof_n;
    logic [NREQ-1:0]        req_src_rdy_n;
    logic [NREQ-1:0]        req_dst_rdy_n;
    logic [DWIDTH-1:0]      tx_d;
    logic [REM_W-1:0]       tx_rem;
    logic                   tx_sof_n;
    logic                   tx_eof_n;
    logic                   tx_src_rdy_n;
    logic                   tx_dst_rdy_n;
    logic [NREQ-1:0]        grant;
    logic                   busy;
    logic                   frame_dropped;
`ifdef AURORA_TX_ARB_STATS_EN
    logic [NREQ*16-1:0]     frame_cnt;
`endif

    aurora_tx_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .REM_W(REM_W)) dut (
        .user_clk      (user_clk),
        .sys_rst_n     (sys_rst_n),
        .channel_up    (channel_up),
        .req_d         (req_d),
        .req_rem       (req_rem),
        .req_sof_n     (req_sof_n),
        .req_eof_n     (req_eof_n),
        .req_src_rdy_n (req_src_rdy_n),
        .req_dst_rdy_n (req_dst_rdy_n),
        .tx_d          (tx_d),
        .tx_rem        (tx_rem),
        .tx_sof_n      (tx_sof_n),
        .tx_eof_n      (tx_eof_n),
        .tx_src_rdy_n  (tx_src_rdy_n),
        .tx_dst_rdy_n  (tx_dst_rdy_n),
        .grant         (grant),
        .busy          (busy),
        .frame_dropped (frame_dropped)
`ifdef AURORA_TX_ARB_STATS_EN
        ,
        .frame_cnt     (frame_cnt)
`endif
    );

    always #5 user_clk = ~user_clk;

    int tests = 0;
    int fails = 0;

    // requester drivers: each holds at most one frame, tracked as length and beat position
    bit drv_active [NREQ];
    bit drv_valid  [NREQ];
    int drv_pos    [NREQ];
    int drv_len    [NREQ];
    int drv_seq    [NREQ];
    int drv_left   [NREQ];
    bit en         [NREQ];

    int flen      = 4;
    int valid_pct = 100;
    int dst_mode  = 0;
    bit rand_cu   = 1'b0;
    bit cu_set    = 1'b1;
    int cu_hold   = 0;

    // reference model: current owner (-1 none), draining flag, next search start, pending drop pulse
    int m_owner, m_flush, m_next, m_drop;
    int n_owner, n_flush, n_next, n_drop;
    int m_cnt [NREQ];

    int obs_beats, obs_single, obs_drop;
    logic [NREQ-1:0] prev_grant;
    logic [NREQ-1:0] grant_seen [$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            if (fails <= 40)
                $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetDrivers();
        for (int i = 0; i < NREQ; i++) begin
            drv_active[i] = 1'b0;
            drv_valid[i]  = 1'b0;
            drv_pos[i]    = 0;
            drv_len[i]    = 1;
            en[i]         = 1'b0;
            drv_left[i]   = 0;
        end
        req_d         = '0;
        req_rem       = '0;
        req_sof_n     = '1;
        req_eof_n     = '1;
        req_src_rdy_n = '1;
    endtask

    task automatic resetModel();
        m_owner = -1; m_flush = 0; m_next = 0; m_drop = 0;
        n_owner = -1; n_flush = 0; n_next = 0; n_drop = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    task automatic clearObs();
        obs_beats  = 0;
        obs_single = 0;
        obs_drop   = 0;
        prev_grant = '0;
        grant_seen.delete();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_tx_d"}, 64'(tx_d), 64'd0);
        checkOutput({tag, "_tx_rem"}, 64'(tx_rem), 64'd0);
        checkOutput({tag, "_tx_sof_n"}, 64'(tx_sof_n), 64'd1);
        checkOutput({tag, "_tx_eof_n"}, 64'(tx_eof_n), 64'd1);
        checkOutput({tag, "_tx_src_rdy_n"}, 64'(tx_src_rdy_n), 64'd1);
        checkOutput({tag, "_req_dst_rdy_n"}, 64'(req_dst_rdy_n), 64'((1 << NREQ) - 1));
        checkOutput({tag, "_grant"}, 64'(grant), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_frame_dropped"}, 64'(frame_dropped), 64'd0);
    endtask

    task automatic applyStimulus();
        logic [NREQ*DWIDTH-1:0] d;
        logic [NREQ*REM_W-1:0]  rem;
        logic [NREQ-1:0]        sof, eof, src;
        d = '0; rem = '0; sof = '1; eof = '1; src = '1;
        for (int i = 0; i < NREQ; i++) begin
            if (!drv_active[i] && en[i] && drv_left[i] != 0) begin
                drv_active[i] = 1'b1;
                drv_pos[i]    = 0;
                drv_len[i]    = (flen > 0) ? flen : int'($urandom_range(1, 8));
                drv_seq[i]++;
            end
            if (drv_active[i]) begin
                drv_valid[i] = ($urandom_range(0, 99) < valid_pct);
                d[i*DWIDTH +: DWIDTH] = {8'(i), 8'(drv_seq[i]), 8'(drv_pos[i]),
                                         24'(drv_seq[i] * 131 + drv_pos[i] * 7)};
                rem[i*REM_W +: REM_W] = REM_W'(drv_pos[i] + i);
                sof[i] = (drv_pos[i] != 0);
                eof[i] = (drv_pos[i] != drv_len[i] - 1);
                src[i] = !drv_valid[i];
            end else begin
                drv_valid[i] = 1'b0;
                d[i*DWIDTH +: DWIDTH] = DWIDTH'({$urandom(), $urandom()});
            end
        end
        req_d = d; req_rem = rem; req_sof_n = sof; req_eof_n = eof; req_src_rdy_n = src;
        case (dst_mode)
            1:       tx_dst_rdy_n = ~tx_dst_rdy_n;
            2:       tx_dst_rdy_n = ($urandom_range(0, 99) >= 75);
            default: tx_dst_rdy_n = 1'b0;
        endcase
        if (rand_cu) begin
            if (cu_hold > 0) begin
                cu_hold--;
                channel_up = 1'b0;
            end else if ($urandom_range(0, 99) < 2) begin
                cu_hold    = int'($urandom_range(0, 4));
                channel_up = 1'b0;
            end else begin
                channel_up = 1'b1;
            end
        end else begin
            channel_up = cu_set;
        end
    endtask

    task automatic evalCycle();
        logic [DWIDTH-1:0] e_d;
        logic [REM_W-1:0]  e_rem;
        logic              e_sof, e_eof, e_src;
        logic [NREQ-1:0]   e_dst, e_grant;
        bit                ok, last;
        e_d = '0; e_rem = '0; e_sof = 1'b1; e_eof = 1'b1; e_src = 1'b1;
        e_dst = '1; e_grant = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            if (m_flush == 0) begin
                e_d            = req_d[m_owner*DWIDTH +: DWIDTH];
                e_rem          = req_rem[m_owner*REM_W +: REM_W];
                e_sof          = req_sof_n[m_owner];
                e_eof          = req_eof_n[m_owner];
                e_src          = req_src_rdy_n[m_owner];
                e_dst[m_owner] = tx_dst_rdy_n;
            end else begin
                e_dst[m_owner] = 1'b0;
            end
        end
        checkOutput("tx_d", 64'(tx_d), 64'(e_d));
        checkOutput("tx_rem", 64'(tx_rem), 64'(e_rem));
        checkOutput("tx_sof_n", 64'(tx_sof_n), 64'(e_sof));
        checkOutput("tx_eof_n", 64'(tx_eof_n), 64'(e_eof));
        checkOutput("tx_src_rdy_n", 64'(tx_src_rdy_n), 64'(e_src));
        checkOutput("req_dst_rdy_n", 64'(req_dst_rdy_n), 64'(e_dst));
        checkOutput("grant", 64'(grant), 64'(e_grant));
        checkOutput("busy", 64'(busy), 64'(m_owner >= 0));
        checkOutput("frame_dropped", 64'(frame_dropped), 64'(m_drop));

        if (tx_src_rdy_n === 1'b0 && tx_dst_rdy_n === 1'b0) begin
            obs_beats++;
            if (tx_sof_n === 1'b0 && tx_eof_n === 1'b0) obs_single++;
        end
        if (frame_dropped === 1'b1) obs_drop++;
        if (grant !== '0 && grant !== prev_grant) grant_seen.push_back(grant);
        prev_grant = grant;

        n_owner = m_owner; n_flush = m_flush; n_next = m_next; n_drop = 0;
        if (m_owner < 0) begin
            if (channel_up) begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (m_next + k) % NREQ;
                    if (n_owner < 0 && drv_active[c] && drv_valid[c] && drv_pos[c] == 0) begin
                        n_owner = c;
                        n_flush = 0;
                    end
                end
            end
        end else begin
            ok   = drv_active[m_owner] && drv_valid[m_owner];
            last = (drv_pos[m_owner] == drv_len[m_owner] - 1);
            if (m_flush == 0) begin
                if (ok && !tx_dst_rdy_n && last) begin
                    n_owner = -1;
                    n_next  = (m_owner + 1) % NREQ;
                    m_cnt[m_owner]++;
                end else if (!channel_up) begin
                    n_flush = 1;
                end
            end else if (ok && last) begin
                n_owner = -1;
                n_next  = (m_owner + 1) % NREQ;
                n_drop  = 1;
            end
        end

        for (int i = 0; i < NREQ; i++) begin
            if (drv_active[i] && drv_valid[i] && e_dst[i] == 1'b0) begin
                drv_pos[i]++;
                if (drv_pos[i] == drv_len[i]) begin
                    drv_active[i] = 1'b0;
                    if (drv_left[i] > 0) drv_left[i]--;
                end
            end
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge user_clk);
            m_owner = n_owner; m_flush = n_flush; m_next = n_next; m_drop = n_drop;
            #1;
            applyStimulus();
            @(negedge user_clk);
            evalCycle();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < NREQ; i++) en[i] = 1'b0;
        runCycles(4);
    endtask

`ifdef AURORA_TX_ARB_STATS_EN
    task automatic checkCounters(input string tag, input int c0, input int c1, input int c2);
        checkOutput({tag, "_cnt0"}, 64'(frame_cnt[0 +: 16]), 64'(16'(c0)));
        checkOutput({tag, "_cnt1"}, 64'(frame_cnt[16 +: 16]), 64'(16'(c1)));
        checkOutput({tag, "_cnt2"}, 64'(frame_cnt[32 +: 16]), 64'(16'(c2)));
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        resetDrivers();
        resetModel();
        clearObs();
        for (int i = 0; i < NREQ; i++) drv_seq[i] = 0;
        tx_dst_rdy_n = 1'b0;
        channel_up   = 1'b1;
        sys_rst_n    = 1'b0;
        req_src_rdy_n[0] = 1'b0;
        req_sof_n[0]     = 1'b0;
        repeat (2) @(posedge user_clk);
        @(negedge user_clk);
        checkReset("reset");
        resetDrivers();
        #2 sys_rst_n = 1'b1;

        $display("[TB] three simultaneous 4-beat frames");
        for (int i = 0; i < NREQ; i++) begin en[i] = 1'b1; drv_left[i] = 1; end
        flen = 4; valid_pct = 100; dst_mode = 0; cu_set = 1'b1;
        clearObs();
        runCycles(16);
        checkOutput("rr_beats", 64'(obs_beats), 64'd12);
        checkOutput("rr_grant_count", 64'(grant_seen.size()), 64'd3);
        for (int g = 0; g < 3; g++)
            checkOutput($sformatf("rr_grant_order%0d", g),
                        64'((g < grant_seen.size()) ? grant_seen[g] : '0), 64'(1 << g));
        drain();

        $display("[TB] back-to-back single-beat frames");
        en[1] = 1'b1; drv_left[1] = 4; flen = 1;
        clearObs();
        runCycles(8);
        checkOutput("single_beats", 64'(obs_beats), 64'd4);
        checkOutput("single_sof_eof", 64'(obs_single), 64'd4);
        drain();

        $display("[TB] 6-beat frame with toggling tx_dst_rdy_n");
        en[0] = 1'b1; drv_left[0] = 1; flen = 6; dst_mode = 1;
        clearObs();
        runCycles(20);
        checkOutput("toggle_beats", 64'(obs_beats), 64'd6);
        dst_mode = 0;
        drain();

        $display("[TB] channel_up low blocks arbitration");
        cu_set = 1'b0; en[2] = 1'b1; drv_left[2] = 1; flen = 2;
        runCycles(5);
        checkOutput("cu_low_grant", 64'(grant), 64'd0);
        cu_set = 1'b1;
        runCycles(2);
        checkOutput("cu_up_grant", 64'(grant), 64'b100);
        runCycles(4);
        drain();

        $display("[TB] randomized traffic");
        for (int i = 0; i < NREQ; i++) begin en[i] = 1'b1; drv_left[i] = -1; end
        flen = 0; valid_pct = 70; dst_mode = 2; rand_cu = 1'b1;
        runCycles(3000);
        rand_cu = 1'b0; cu_set = 1'b1; dst_mode = 0; valid_pct = 100;
        runCycles(2);
`ifdef AURORA_TX_ARB_STATS_EN
        checkCounters("random", m_cnt[0], m_cnt[1], m_cnt[2]);
`endif

        $display("[TB] reset in the middle of a frame");
        k = 0;
        while (m_owner < 0 && k < 200) begin
            runCycles(1);
            k++;
        end
        checkOutput("midreset_found_busy", 64'(m_owner >= 0), 64'd1);
        #1 sys_rst_n = 1'b0;
        #1 checkReset("midreset");
        resetDrivers();
        resetModel();
        #1 sys_rst_n = 1'b1;
        clearObs();
        runCycles(4);
        checkOutput("midreset_no_drop", 64'(obs_drop), 64'd0);
`ifdef AURORA_TX_ARB_STATS_EN
        checkCounters("midreset", 0, 0, 0);
`endif

        $display("[TB] completed and flushed frames from requester 1");
        en[1] = 1'b1; drv_left[1] = 3; flen = 3;
        clearObs();
        runCycles(20);
        checkOutput("stats_beats", 64'(obs_beats), 64'd9);
        flen = 8; drv_left[1] = 1;
        k = 0;
        while (!(drv_active[1] && drv_pos[1] >= 2) && k < 50) begin
            runCycles(1);
            k++;
        end
        checkOutput("flush_setup", 64'(drv_active[1] && drv_pos[1] >= 2), 64'd1);
        cu_set = 1'b0;
        runCycles(14);
        cu_set = 1'b1;
        runCycles(3);
        checkOutput("flush_drop_pulses", 64'(obs_drop), 64'd1);
        checkOutput("flush_idle", 64'(busy), 64'd0);
`ifdef AURORA_TX_ARB_STATS_EN
        checkCounters("stats", 0, 3, 0);
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
